// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings, slave FSM states and byte-enable helper
package ahb_pkg;
  typedef enum logic [1:0] {HT_IDLE = 2'b00, HT_BUSY = 2'b01, HT_NONSEQ = 2'b10, HT_SEQ = 2'b11} htrans_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;
  localparam logic [2:0] SIZE_DWORD = 3'd3;
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_ERR1, ST_ERR2} slave_state_t;
  function automatic logic [7:0] be_gen(input logic [2:0] size, input logic [2:0] addr_lo, input int nbytes);
    logic [7:0] ones;
    ones = 8'hFF >> (4'd8 - (4'd1 << size));
    return (ones << addr_lo) & (8'hFF >> (8 - nbytes));
  endfunction
endpackage

// File: rtl/sram_be.sv
// sram_be: single-port RAM with per-byte write enables and asynchronous read
module sram_be #(
  parameter int DW = 32,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic [DW/8-1:0]          we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    for (int i = 0; i < DW/8; i++)
      if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
  assign rdata = mem[addr];
endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: pipelined AHB-Lite on-chip RAM target with wait states and ERROR response
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          NSEQ_WAIT   = 2,
  parameter int          SEQ_WAIT    = 0,
  parameter bit          READ_ONLY   = 1'b0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LB = $clog2(BYTES);
  localparam int LD = $clog2(DEPTH_WORDS);
  localparam logic [31:0] REGION = 32'(DEPTH_WORDS * BYTES);
  slave_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [LD-1:0] idx_q, idx_d;
  logic [LB-1:0] lo_q, lo_d;
  logic [2:0] size_q, size_d;
  logic write_q, write_d;
  logic [31:0] offset;
  logic capture, illegal;
  logic [3:0] wait_n;
  logic [BYTES-1:0] be, we;
  logic [DATA_WIDTH-1:0] lane_mask, rdata;
  assign offset = HADDR - BASE_ADDR;
  assign capture = HSEL & HREADY & HTRANS[1] &
                   (state_q == ST_IDLE || state_q == ST_ACCESS || state_q == ST_ERR2);
  assign illegal = (offset >= REGION) | (HSIZE > 3'(LB)) |
                   (|(HADDR & ((32'd1 << HSIZE) - 32'd1))) | (READ_ONLY & HWRITE);
  assign wait_n = HTRANS[0] ? 4'(SEQ_WAIT) : 4'(NSEQ_WAIT);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    lo_d = lo_q;
    size_d = size_q;
    write_d = write_q;
    if (capture) begin
      idx_d = offset[LD+LB-1:LB];
      lo_d = offset[LB-1:0];
      size_d = HSIZE;
      write_d = HWRITE;
      cnt_d = wait_n;
      state_d = illegal ? ST_ERR1 : (wait_n != 4'd0 ? ST_WAIT : ST_ACCESS);
    end else if (state_q == ST_WAIT) begin
      cnt_d = cnt_q - 4'd1;
      state_d = cnt_q == 4'd1 ? ST_ACCESS : ST_WAIT;
    end else begin
      state_d = state_q == ST_ERR1 ? ST_ERR2 : ST_IDLE;
    end
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      lo_q <= '0;
      size_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      lo_q <= lo_d;
      size_q <= size_d;
      write_q <= write_d;
    end
  end
  assign be = BYTES'(be_gen(size_q, 3'(lo_q), BYTES));
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < BYTES; i++) lane_mask[i*8 +: 8] = {8{be[i]}};
  end
  // Reset in the closing cycle of a write still drops it
  assign we = (state_q == ST_ACCESS && write_q && !HRESET) ? be : '0;
  assign HREADYOUT = !(state_q == ST_WAIT || state_q == ST_ERR1);
  assign HRESP = (state_q == ST_ERR1 || state_q == ST_ERR2) ? RESP_ERROR : RESP_OKAY;
  assign HRDATA = (state_q == ST_ACCESS && !write_q) ? (rdata & lane_mask) : '0;
  sram_be #(.DW(DATA_WIDTH), .DEPTH(DEPTH_WORDS)) u_ram (
    .clk  (HCLK),
    .we   (we),
    .addr (idx_q),
    .wdata(HWDATA),
    .rdata(rdata)
  );
endmodule
